vga_timing_ctrl: RTL and testbench



---
 rtl/vga_timing_ctrl_if.sv | 10 +
 rtl/vga_timing_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/vga_timing_ctrl_if.sv
// Pixel-buffer link between the ping-pong buffer and the VGA timing controller.
// The timing controller is the master: it raises data_req for one cycle per
// pixel and the buffer answers on data in the following cycle.
interface vga_timing_ctrl_if;
  logic        data_req;
  logic [11:0] data;

  modport master (output data_req, input data);
  modport slave  (input data_req, output data);
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: raster counters, region decode and a fixed 3-stage
// output pipeline. Display start/stop only takes effect on frame boundaries,
// so every frame that reaches the pins is complete.
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                      clk_v,
  input  logic                      resetn_v,
  input  logic                      en_i,
  vga_timing_ctrl_if.master         buf_if,
  output logic                      frame_start_o,
  output logic                      hsync_o,
  output logic                      vsync_o,
  output logic                      de_o,
  output logic [11:0]               rgb_o,
  output logic                      busy_o
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Region bounds are kept one bit wider than the counters so a sync pulse
  // ending exactly at 4096 does not wrap to zero.
  localparam logic [11:0] H_LAST   = 12'(H_TOT - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOT - 1);
  localparam logic [12:0] H_ACT_E  = 13'(H_ACTIVE);
  localparam logic [12:0] V_ACT_E  = 13'(V_ACTIVE);
  localparam logic [12:0] HS_BEG   = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] VS_BEG   = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [11:0] h_cnt_r;
  logic [11:0] v_cnt_r;
  logic [11:0] h_nxt_s;
  logic [11:0] v_nxt_s;
  logic        running_s;
  logic        line_end_s;
  logic        frame_end_s;
  logic        active_s;
  logic        hs_s;
  logic        vs_s;
  logic        origin_s;

  // Stage 1/2 carry the decode alongside the buffer round trip.
  logic        data_req_r;
  logic        frame_start_r;
  logic        de1_r;
  logic        hs1_r;
  logic        vs1_r;
  logic        de2_r;
  logic        hs2_r;
  logic        vs2_r;
  logic        hsync_r;
  logic        vsync_r;
  logic        de_r;
  logic [11:0] rgb_r;
  logic        busy_r;

  assign running_s   = (state_r == ST_RUN) || (state_r == ST_STOP);
  assign line_end_s  = (h_cnt_r == H_LAST);
  assign frame_end_s = line_end_s && (v_cnt_r == V_LAST);

  // Next FSM state: enable changes are honoured, but leaving the raster only
  // happens on the last pixel of a frame.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en_i) state_nxt_s = ST_RUN;
        else      state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (en_i)             state_nxt_s = ST_RUN;
        else if (frame_end_s) state_nxt_s = ST_IDLE;
        else                  state_nxt_s = ST_STOP;
      end
      ST_STOP: begin
        if (en_i)             state_nxt_s = ST_RUN;
        else if (frame_end_s) state_nxt_s = ST_IDLE;
        else                  state_nxt_s = ST_STOP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next raster position: held at the origin while idle, otherwise h wraps
  // each line and v steps on every h wrap.
  always_comb begin
    h_nxt_s = 12'd0;
    v_nxt_s = 12'd0;
    if (!running_s) begin
      h_nxt_s = 12'd0;
      v_nxt_s = 12'd0;
    end else if (line_end_s) begin
      h_nxt_s = 12'd0;
      if (frame_end_s) v_nxt_s = 12'd0;
      else             v_nxt_s = v_cnt_r + 12'd1;
    end else begin
      h_nxt_s = h_cnt_r + 12'd1;
      v_nxt_s = v_cnt_r;
    end
  end

  // Region decode of the current position, forced inactive while idle.
  always_comb begin
    active_s = 1'b0;
    hs_s     = 1'b0;
    vs_s     = 1'b0;
    origin_s = 1'b0;
    if (running_s) begin
      active_s = ({1'b0, h_cnt_r} < H_ACT_E) && ({1'b0, v_cnt_r} < V_ACT_E);
      hs_s     = ({1'b0, h_cnt_r} >= HS_BEG) && ({1'b0, h_cnt_r} < HS_END);
      vs_s     = ({1'b0, v_cnt_r} >= VS_BEG) && ({1'b0, v_cnt_r} < VS_END);
      origin_s = (h_cnt_r == 12'd0) && (v_cnt_r == 12'd0);
    end else begin
      active_s = 1'b0;
      hs_s     = 1'b0;
      vs_s     = 1'b0;
      origin_s = 1'b0;
    end
  end

  // FSM, raster counters and busy flag (busy mirrors the registered state).
  always_ff @(posedge clk_v or negedge resetn_v) begin
    if (!resetn_v) begin
      state_r <= ST_IDLE;
      h_cnt_r <= 12'd0;
      v_cnt_r <= 12'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      h_cnt_r <= h_nxt_s;
      v_cnt_r <= v_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  // Output pipeline: request at T+1, buffer data arrives at T+2, pins at T+3.
  // data is only looked at in the cycle after a request (de2_r).
  always_ff @(posedge clk_v or negedge resetn_v) begin
    if (!resetn_v) begin
      data_req_r    <= 1'b0;
      frame_start_r <= 1'b0;
      de1_r         <= 1'b0;
      hs1_r         <= 1'b0;
      vs1_r         <= 1'b0;
      de2_r         <= 1'b0;
      hs2_r         <= 1'b0;
      vs2_r         <= 1'b0;
      de_r          <= 1'b0;
      rgb_r         <= 12'h000;
      hsync_r       <= ~SYNC_POL;
      vsync_r       <= ~SYNC_POL;
    end else begin
      data_req_r    <= active_s;
      frame_start_r <= origin_s;
      de1_r         <= active_s;
      hs1_r         <= hs_s;
      vs1_r         <= vs_s;
      de2_r         <= de1_r;
      hs2_r         <= hs1_r;
      vs2_r         <= vs1_r;
      de_r          <= de2_r;
      rgb_r         <= de2_r ? buf_if.data : 12'h000;
      hsync_r       <= hs2_r ? SYNC_POL : ~SYNC_POL;
      vsync_r       <= vs2_r ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign buf_if.data_req = data_req_r;
  assign frame_start_o   = frame_start_r;
  assign hsync_o         = hsync_r;
  assign vsync_o         = vsync_r;
  assign de_o            = de_r;
  assign rgb_o           = rgb_r;
  assign busy_o          = busy_r;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomized bench for vga_timing_ctrl using a shrunken raster so many whole
// frames, enable drops and restarts fit in a short run. Two instances share
// the stimulus: one with active-low syncs and one with active-high syncs.
module tb_vga_timing_ctrl;

  localparam int HA  = 8;
  localparam int HFP = 2;
  localparam int HS  = 3;
  localparam int HBP = 2;
  localparam int VA  = 4;
  localparam int VFP = 1;
  localparam int VS  = 2;
  localparam int VBP = 1;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FR  = HT * VT;
  localparam int N_CYC   = 4000;
  localparam int RST_CYC = 1500;

  logic        clk_v;
  logic        resetn_v;
  logic        en_i;
  logic        fs0, hsy0, vsy0, de0, busy0;
  logic        fs1, hsy1, vsy1, de1, busy1;
  logic [11:0] rgb0, rgb1;

  vga_timing_ctrl_if bus0 ();
  vga_timing_ctrl_if bus1 ();

  vga_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
                    .SYNC_POL(1'b0)) dut0 (
    .clk_v(clk_v), .resetn_v(resetn_v), .en_i(en_i), .buf_if(bus0),
    .frame_start_o(fs0), .hsync_o(hsy0), .vsync_o(vsy0), .de_o(de0),
    .rgb_o(rgb0), .busy_o(busy0));

  vga_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
                    .SYNC_POL(1'b1)) dut1 (
    .clk_v(clk_v), .resetn_v(resetn_v), .en_i(en_i), .buf_if(bus1),
    .frame_start_o(fs1), .hsync_o(hsy1), .vsync_o(vsy1), .de_o(de1),
    .rgb_o(rgb1), .busy_o(busy1));

  initial clk_v = 1'b0;
  always #5 clk_v = ~clk_v;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %03h expected %03h at time %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: whether a frame is being emitted and the linear position
  // inside the frame; raster coordinates come from division/modulo.
  bit          m_run;
  int          m_pos;
  bit          prev_en;
  logic [11:0] prev_d;
  logic [11:0] cur_d;
  bit          h_act [0:3];
  bit          h_hs  [0:3];
  bit          h_vs  [0:3];
  bit          h_fs  [0:3];

  task automatic clear_hist();
    for (int k = 0; k < 4; k++) begin
      h_act[k] = 1'b0; h_hs[k] = 1'b0; h_vs[k] = 1'b0; h_fs[k] = 1'b0;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk_eq({tag, "_busy"},  {11'd0, busy0},         12'd0);
    chk_eq({tag, "_req"},   {11'd0, bus0.data_req}, 12'd0);
    chk_eq({tag, "_fs"},    {11'd0, fs0},           12'd0);
    chk_eq({tag, "_de"},    {11'd0, de0},           12'd0);
    chk_eq({tag, "_rgb"},   rgb0,                   12'h000);
    chk_eq({tag, "_hs0"},   {11'd0, hsy0},          12'd1);
    chk_eq({tag, "_vs0"},   {11'd0, vsy0},          12'd1);
    chk_eq({tag, "_hs1"},   {11'd0, hsy1},          12'd0);
    chk_eq({tag, "_vs1"},   {11'd0, vsy1},          12'd0);
    chk_eq({tag, "_busy1"}, {11'd0, busy1},         12'd0);
  endtask

  initial begin
    int  h, v;
    bit  a, hs, vs, fs;
    resetn_v  = 1'b0;
    en_i      = 1'b0;
    bus0.data = 12'h000;
    bus1.data = 12'h000;
    m_run = 1'b0; m_pos = 0; prev_en = 1'b0; prev_d = 12'h000;
    clear_hist();
    repeat (3) @(posedge clk_v);
    #1;
    check_reset_values("por");
    @(negedge clk_v);
    resetn_v = 1'b1;

    for (int c = 0; c < N_CYC; c++) begin
      @(posedge clk_v);
      #1;
      // Advance the model to this cycle: a new frame starts when enable was
      // seen while idle or on the last pixel of the previous frame.
      if (!m_run || m_pos == FR - 1) begin
        m_run = prev_en;
        m_pos = 0;
      end else begin
        m_pos = m_pos + 1;
      end
      h  = m_pos % HT;
      v  = m_pos / HT;
      a  = m_run && h < HA && v < VA;
      hs = m_run && h >= HA + HFP && h < HA + HFP + HS;
      vs = m_run && v >= VA + VFP && v < VA + VFP + VS;
      fs = m_run && m_pos == 0;
      for (int k = 3; k > 0; k--) begin
        h_act[k] = h_act[k-1]; h_hs[k] = h_hs[k-1];
        h_vs[k]  = h_vs[k-1];  h_fs[k] = h_fs[k-1];
      end
      h_act[0] = a; h_hs[0] = hs; h_vs[0] = vs; h_fs[0] = fs;

      chk_eq("busy",    {11'd0, busy0},         {11'd0, m_run});
      chk_eq("req",     {11'd0, bus0.data_req}, {11'd0, h_act[1]});
      chk_eq("fstart",  {11'd0, fs0},           {11'd0, h_fs[1]});
      chk_eq("de",      {11'd0, de0},           {11'd0, h_act[3]});
      chk_eq("rgb",     rgb0,                   h_act[3] ? prev_d : 12'h000);
      chk_eq("hsync0",  {11'd0, hsy0},          {11'd0, ~h_hs[3]});
      chk_eq("vsync0",  {11'd0, vsy0},          {11'd0, ~h_vs[3]});
      chk_eq("hsync1",  {11'd0, hsy1},          {11'd0, h_hs[3]});
      chk_eq("vsync1",  {11'd0, vsy1},          {11'd0, h_vs[3]});
      chk_eq("req1",    {11'd0, bus1.data_req}, {11'd0, h_act[1]});
      chk_eq("de1",     {11'd0, de1},           {11'd0, h_act[3]});

      // New inputs for this cycle: enable toggles occasionally so frames
      // run, stop, restart and get cut by stop-at-frame-end.
      if (c == 5) en_i = 1'b1;
      else if (c > 5 && $urandom_range(0, 59) == 0) en_i = ~en_i;
      cur_d     = 12'($urandom);
      bus0.data = cur_d;
      bus1.data = cur_d;
      prev_en   = en_i;
      prev_d    = cur_d;

      // Asynchronous reset pulse in the middle of a cycle, mid-frame.
      if (c == RST_CYC) begin
        #1 resetn_v = 1'b0;
        #1 check_reset_values("async_rst");
        #1 resetn_v = 1'b1;
        m_run = 1'b0;
        m_pos = 0;
        clear_hist();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
